// File: rtl/rpc2_ctrl_cfg_sync_stable.sv
// ============================================================================
// Module   : rpc2_ctrl_cfg_sync_stable
// Purpose  : Per-channel configuration synchronizer with stability filter and
//            transaction-aware commit into the memory clock domain.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rpc2_ctrl_cfg_sync_stable #(
  parameter int unsigned     NUM_CH      = 2,
  parameter int unsigned     CH_W        = 32,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter int unsigned     STABLE_CYC  = 4,
  parameter logic [CH_W-1:0] RESET_VAL   = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*CH_W-1:0]   cfg_in,
  input  logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH*CH_W-1:0]   cfg_out,
  output logic [NUM_CH-1:0]        cfg_upd,
  output logic [NUM_CH-1:0]        cfg_pending
);

  localparam int unsigned      CNT_W   = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_QUAL = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0][CH_W-1:0] sync_q, sync_d;
    logic [CH_W-1:0]  s;
    logic [CH_W-1:0]  cand_q, cand_d;
    logic [CH_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic             upd_q, upd_d;
    logic             pend_q, pend_d;
    logic             commit;

    // Stage 0 takes the raw asynchronous word; the last stage is the safe sample.
    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], cfg_in[c*CH_W +: CH_W]};
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q  <= {SYNC_STAGES{RESET_VAL}};
        cand_q  <= RESET_VAL;
        out_q   <= RESET_VAL;
        cnt_q   <= '0;
        state_q <= ST_IDLE;
        upd_q   <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        cand_q  <= cand_d;
        out_q   <= out_d;
        cnt_q   <= cnt_d;
        state_q <= state_d;
        upd_q   <= upd_d;
        pend_q  <= pend_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      commit  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s != out_q) begin
            cand_d  = s;
            cnt_d   = CNT_ONE;
            state_d = ST_QUAL;
          end
        end
        ST_QUAL: begin
          if (s != cand_q) begin
            if (s == out_q) begin
              state_d = ST_IDLE;
            end else begin
              cand_d = s;
              cnt_d  = CNT_ONE;
            end
          end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end else if (!ch_busy[c]) begin
            out_d   = cand_q;
            commit  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PEND;
          end
        end
        ST_PEND: begin
          // A changed sample while waiting restarts qualification from scratch.
          if (s != cand_q) begin
            if (s == out_q) begin
              state_d = ST_IDLE;
            end else begin
              cand_d  = s;
              cnt_d   = CNT_ONE;
              state_d = ST_QUAL;
            end
          end else if (!ch_busy[c]) begin
            out_d   = cand_q;
            commit  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Pulse only on a real change of the committed word.
    always_comb begin
      upd_d  = commit && (cand_q != out_q);
      pend_d = (state_d == ST_PEND);
    end

    assign cfg_out[c*CH_W +: CH_W] = out_q;
    assign cfg_upd[c]              = upd_q;
    assign cfg_pending[c]          = pend_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_rpc2_ctrl_cfg_sync_stable.sv
// ============================================================================
// Module   : tb_rpc2_ctrl_cfg_sync_stable
// Purpose  : Directed self-checking bench for the configuration synchronizer,
//            default parameters plus a narrow/shallow variant.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rpc2_ctrl_cfg_sync_stable;

  logic        clk = 1'b0;
  logic        rst_n_a, rst_n_b;
  logic [63:0] cfg_in_a;
  logic [1:0]  busy_a;
  logic [63:0] cfg_out_a;
  logic [1:0]  upd_a, pend_a;
  logic [35:0] cfg_in_b;
  logic [3:0]  busy_b;
  logic [35:0] cfg_out_b;
  logic [3:0]  upd_b, pend_b;

  int checks   = 0;
  int failures = 0;
  int upd_cnt;

  always #5 clk = ~clk;

  rpc2_ctrl_cfg_sync_stable dut_a (
    .clk         (clk),
    .reset_n     (rst_n_a),
    .cfg_in      (cfg_in_a),
    .ch_busy     (busy_a),
    .cfg_out     (cfg_out_a),
    .cfg_upd     (upd_a),
    .cfg_pending (pend_a)
  );

  rpc2_ctrl_cfg_sync_stable #(
    .NUM_CH      (4),
    .CH_W        (9),
    .SYNC_STAGES (3),
    .STABLE_CYC  (1)
  ) dut_b (
    .clk         (clk),
    .reset_n     (rst_n_b),
    .cfg_in      (cfg_in_b),
    .ch_busy     (busy_b),
    .cfg_out     (cfg_out_b),
    .cfg_upd     (upd_b),
    .cfg_pending (pend_b)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; returns 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Same as tick but counts cycles with any update pulse on either DUT.
  task automatic tick_count(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (upd_a != 2'b00 || upd_b != 4'b0000) upd_cnt++;
    end
  endtask

  initial begin
    rst_n_a  = 1'b0;
    rst_n_b  = 1'b0;
    cfg_in_a = '0;
    cfg_in_b = '0;
    busy_a   = '0;
    busy_b   = '0;
    tick(3);
    check_val("a_rst_out",  cfg_out_a, 64'h0);
    check_val("a_rst_upd",  upd_a, 2'b00);
    check_val("a_rst_pend", pend_a, 2'b00);
    check_val("b_rst_out",  cfg_out_b, 36'h0);

    // ---------------- default-parameter instance ----------------
    rst_n_a = 1'b1;
    upd_cnt = 0;
    tick_count(50);
    check_val("a_no_upd_after_rst", upd_cnt, 0);

    cfg_in_a[31:0] = 32'hA5A5_0001;
    tick(6);
    check_val("a_ch0_before_e6", cfg_out_a[31:0], 32'h0);
    check_val("a_upd_before_e6", upd_a, 2'b00);
    tick(1);
    check_val("a_ch0_at_e6", cfg_out_a[31:0], 32'hA5A5_0001);
    check_val("a_upd_at_e6", upd_a, 2'b01);
    check_val("a_ch1_unchanged", cfg_out_a[63:32], 32'h0);
    tick(1);
    check_val("a_upd_one_cycle", upd_a, 2'b00);

    // Glitch returning to the committed value
    cfg_in_a[63:32] = 32'h1234;
    tick(2);
    cfg_in_a[63:32] = 32'h0;
    upd_cnt = 0;
    tick_count(12);
    check_val("a_glitch_back_no_upd", upd_cnt, 0);
    check_val("a_glitch_back_out", cfg_out_a[63:32], 32'h0);
    check_val("a_glitch_back_idle", dut_a.g_ch[1].state_q, 2'd0);

    // Glitch followed by a new held value
    cfg_in_a[63:32] = 32'h1234;
    tick(2);
    cfg_in_a[63:32] = 32'h5678;
    upd_cnt = 0;
    tick_count(6);
    check_val("a_glitch_new_early_upd", upd_cnt, 0);
    check_val("a_glitch_new_early_out", cfg_out_a[63:32], 32'h0);
    tick(1);
    check_val("a_glitch_new_out", cfg_out_a[63:32], 32'h5678);
    check_val("a_glitch_new_upd", upd_a, 2'b10);
    tick(1);
    check_val("a_glitch_new_upd_clr", upd_a, 2'b00);

    // Busy channel parks in PEND, commits on busy drop
    busy_a[0]      = 1'b1;
    cfg_in_a[31:0] = 32'h0000_00FF;
    tick(6);
    check_val("a_busy_pend_early", pend_a, 2'b00);
    tick(1);
    check_val("a_busy_pend", pend_a, 2'b01);
    check_val("a_busy_out_hold", cfg_out_a[31:0], 32'hA5A5_0001);
    check_val("a_busy_no_upd", upd_a, 2'b00);
    tick(3);
    check_val("a_busy_pend_hold", pend_a, 2'b01);
    busy_a[0] = 1'b0;
    tick(1);
    check_val("a_busy_commit_out", cfg_out_a[31:0], 32'h0000_00FF);
    check_val("a_busy_commit_upd", upd_a, 2'b01);
    check_val("a_busy_commit_pend", pend_a, 2'b00);
    tick(1);
    check_val("a_busy_upd_clr", upd_a, 2'b00);

    // PEND interrupted by a new value -> re-qualify and commit
    busy_a[0]      = 1'b1;
    cfg_in_a[31:0] = 32'h0000_1111;
    tick(7);
    check_val("a_req_pend", pend_a, 2'b01);
    cfg_in_a[31:0] = 32'h0000_0F0F;
    tick(2);
    check_val("a_req_pend_hold", pend_a, 2'b01);
    tick(1);
    check_val("a_req_pend_drop", pend_a, 2'b00);
    busy_a[0] = 1'b0;
    tick(3);
    check_val("a_req_out_hold", cfg_out_a[31:0], 32'h0000_00FF);
    tick(1);
    check_val("a_req_out", cfg_out_a[31:0], 32'h0000_0F0F);
    check_val("a_req_upd", upd_a, 2'b01);

    // PEND interrupted by the committed value -> IDLE, no pulse
    busy_a[0]      = 1'b1;
    cfg_in_a[31:0] = 32'h0000_2222;
    tick(7);
    check_val("a_back_pend", pend_a, 2'b01);
    cfg_in_a[31:0] = 32'h0000_0F0F;
    tick(3);
    check_val("a_back_pend_drop", pend_a, 2'b00);
    busy_a[0] = 1'b0;
    upd_cnt   = 0;
    tick_count(10);
    check_val("a_back_no_upd", upd_cnt, 0);
    check_val("a_back_out", cfg_out_a[31:0], 32'h0000_0F0F);
    check_val("a_back_idle", dut_a.g_ch[0].state_q, 2'd0);

    // Asynchronous reset mid-QUAL
    cfg_in_a[31:0] = 32'h0000_3333;
    tick(3);
    #2 rst_n_a = 1'b0;
    #1;
    check_val("a_rst_qual_out", cfg_out_a, 64'h0);
    check_val("a_rst_qual_upd", upd_a, 2'b00);
    check_val("a_rst_qual_pend", pend_a, 2'b00);
    cfg_in_a = '0;
    tick(2);
    rst_n_a = 1'b1;

    // Asynchronous reset mid-PEND
    busy_a[0]      = 1'b1;
    cfg_in_a[31:0] = 32'h0000_4444;
    tick(7);
    check_val("a_pre_rst_pend", pend_a, 2'b01);
    #2 rst_n_a = 1'b0;
    #1;
    check_val("a_rst_pend_pend", pend_a, 2'b00);
    check_val("a_rst_pend_out", cfg_out_a, 64'h0);
    cfg_in_a = '0;
    busy_a   = '0;
    tick(2);
    rst_n_a = 1'b1;
    upd_cnt = 0;
    tick_count(10);
    check_val("a_post_rst_no_upd", upd_cnt, 0);

    // ---------------- NUM_CH=4 CH_W=9 SYNC=3 STABLE=1 ----------------
    rst_n_b = 1'b1;
    upd_cnt = 0;
    tick_count(20);
    check_val("b_no_upd_after_rst", upd_cnt, 0);

    cfg_in_b[26:18] = 9'h1A5;
    tick(4);
    check_val("b_ch2_before_e4", cfg_out_b[26:18], 9'h0);
    tick(1);
    check_val("b_ch2_at_e4", cfg_out_b[26:18], 9'h1A5);
    check_val("b_upd_at_e4", upd_b, 4'b0100);
    check_val("b_other_ch", {cfg_out_b[35:27], cfg_out_b[17:0]}, 27'h0);
    tick(1);
    check_val("b_upd_clr", upd_b, 4'b0000);

    // Single-sample glitch never reaches STABLE_CYC
    cfg_in_b[8:0] = 9'h011;
    tick(1);
    cfg_in_b[8:0] = 9'h000;
    upd_cnt = 0;
    tick_count(8);
    check_val("b_glitch_no_upd", upd_cnt, 0);
    check_val("b_glitch_out", cfg_out_b[8:0], 9'h0);

    busy_b[3]       = 1'b1;
    cfg_in_b[35:27] = 9'h0FF;
    tick(5);
    check_val("b_busy_pend", pend_b, 4'b1000);
    check_val("b_busy_out_hold", cfg_out_b[35:27], 9'h0);
    tick(2);
    busy_b[3] = 1'b0;
    tick(1);
    check_val("b_busy_commit_out", cfg_out_b[35:27], 9'h0FF);
    check_val("b_busy_commit_upd", upd_b, 4'b1000);
    check_val("b_busy_commit_pend", pend_b, 4'b0000);

    busy_b[3]       = 1'b1;
    cfg_in_b[35:27] = 9'h033;
    tick(5);
    check_val("b_pre_rst_pend", pend_b, 4'b1000);
    #2 rst_n_b = 1'b0;
    #1;
    check_val("b_rst_pend_pend", pend_b, 4'b0000);
    check_val("b_rst_pend_out", cfg_out_b, 36'h0);
    check_val("b_rst_pend_upd", upd_b, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
